// File: rtl/hdmi_packet_pkg.sv
// HDMI data island packet type codes, shared by the scheduler, the packet
// generators and the header/subpacket mux.
package hdmi_packet_pkg;

    localparam logic [7:0] PKT_NULL            = 8'h00;
    localparam logic [7:0] PKT_ACR             = 8'h01;
    localparam logic [7:0] PKT_AUDIO_SAMPLE    = 8'h02;
    localparam logic [7:0] PKT_AVI             = 8'h82;
    localparam logic [7:0] PKT_AUDIO_INFOFRAME = 8'h84;

endpackage

// File: rtl/audio_sample_fifo.sv
// Synchronous FIFO for stereo audio samples; DEPTH must be a power of two so
// the pointers wrap on their own. Read data is shown from the head entry.
module audio_sample_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 40
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [PW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    end

    // Storage carries no reset; occupancy alone defines what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/packet_scheduler.sv
// Chooses the packet type for each HDMI data island slot and feeds buffered
// audio samples to the sample generator. Optional macro:
// PACKET_SCHEDULER_INFOFRAME_EN enables AVI / audio InfoFrame scheduling.
module packet_scheduler
    import hdmi_packet_pkg::*;
#(
    parameter int ACR_PERIOD      = 27000,
    parameter int FIFO_DEPTH      = 4,
    parameter int AUDIO_BIT_WIDTH = 20
) (
    input  logic                            clk_pixel,
    input  logic                            reset,
    input  logic                            video_frame_start,
    input  logic                            packet_enable,
    input  logic                            audio_sample_valid,
    output logic                            audio_sample_ready,
    input  logic [1:0][AUDIO_BIT_WIDTH-1:0] audio_sample_word,
    output logic [7:0]                      packet_type,
    output logic [1:0][AUDIO_BIT_WIDTH-1:0] sample_word_out,
    output logic                            asp_advance
);

    localparam int ACR_W = (ACR_PERIOD > 2) ? $clog2(ACR_PERIOD) : 1;
    localparam int SW    = 2 * AUDIO_BIT_WIDTH;

    logic [ACR_W-1:0] acr_count;
    logic             acr_wrap;
    logic             acr_pending;
    logic             avi_pending;
    logic             aif_pending;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_pop;
    logic [SW-1:0]    fifo_dout;
    logic [7:0]       sel_type;

    assign audio_sample_ready = !fifo_full;
    assign acr_wrap           = (acr_count == ACR_W'(ACR_PERIOD - 1));

    audio_sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (SW)
    ) u_fifo (
        .clk   (clk_pixel),
        .reset (reset),
        .push  (audio_sample_valid),
        .pop   (fifo_pop),
        .din   (audio_sample_word),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Priority works on registered state, so this cycle's push or flag set
    // only becomes eligible at the next slot.
    always_comb begin
        sel_type = PKT_NULL;
        fifo_pop = 1'b0;
        if (acr_pending) begin
            sel_type = PKT_ACR;
        end else if (!fifo_empty) begin
            sel_type = PKT_AUDIO_SAMPLE;
            fifo_pop = packet_enable;
        end else if (avi_pending) begin
            sel_type = PKT_AVI;
        end else if (aif_pending) begin
            sel_type = PKT_AUDIO_INFOFRAME;
        end
    end

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            acr_count   <= '0;
            acr_pending <= 1'b0;
        end else begin
            acr_count <= acr_wrap ? '0 : acr_count + 1'b1;
            if (packet_enable && sel_type == PKT_ACR) acr_pending <= 1'b0;
            if (acr_wrap) acr_pending <= 1'b1;
        end
    end

`ifdef PACKET_SCHEDULER_INFOFRAME_EN
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            avi_pending <= 1'b0;
            aif_pending <= 1'b0;
        end else begin
            if (packet_enable && sel_type == PKT_AVI)             avi_pending <= 1'b0;
            if (packet_enable && sel_type == PKT_AUDIO_INFOFRAME) aif_pending <= 1'b0;
            if (video_frame_start) begin
                avi_pending <= 1'b1;
                aif_pending <= 1'b1;
            end
        end
    end
`else
    logic unused_frame_start;
    assign unused_frame_start = video_frame_start;
    assign avi_pending        = 1'b0;
    assign aif_pending        = 1'b0;
`endif

    // sample_word_out only changes when an audio sample slot is chosen.
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            packet_type     <= PKT_NULL;
            sample_word_out <= '0;
            asp_advance     <= 1'b0;
        end else begin
            asp_advance <= packet_enable && (sel_type == PKT_AUDIO_SAMPLE);
            if (packet_enable) begin
                packet_type <= sel_type;
                if (sel_type == PKT_AUDIO_SAMPLE) sample_word_out <= fifo_dout;
            end
        end
    end

endmodule

// File: doc/packet_scheduler.md
# packet_scheduler

Decides, per HDMI data island packet slot, which packet is transmitted: audio clock regeneration (ACR), audio sample, AVI/audio InfoFrame or null. Buffers incoming stereo audio samples in a small FIFO and issues the advance strobe that steps the audio sample generator's IEC 60958 frame counter. Sits between the audio source and the packet generators; its `packet_type` drives the header/subpacket mux ahead of the TERC4 encoder.

## Interface
Parameters:
- `ACR_PERIOD`, 27000: clk_pixel cycles between ACR requests (≈1 ms at 27 MHz); ≥ 2.
- `FIFO_DEPTH`, 4: audio sample FIFO entries; power of two, ≥ 2.
- `AUDIO_BIT_WIDTH`, 20: bits per channel sample.

Ports (one clock, `clk_pixel`; reset `reset` is synchronous, active-high):
- `clk_pixel` input 1: pixel clock; all logic on rising edge.
- `reset` input 1: synchronous active-high reset.
- `video_frame_start` input 1: one-cycle pulse at the start of each video frame.
- `packet_enable` input 1: one-cycle pulse; a new 32-cycle packet slot begins.
- `audio_sample_valid` input 1: sample offered.
- `audio_sample_ready` output 1: FIFO not full.
- `audio_sample_word` input [AUDIO_BIT_WIDTH-1:0] ×2 (`[1:0]`): right [1], left [0].
- `packet_type` output 8: HDMI type code of the current slot.
- `sample_word_out` output [AUDIO_BIT_WIDTH-1:0] ×2: sample for the audio sample generator.
- `asp_advance` output 1: one-cycle pulse; audio sample generator steps its frame counter.

## Operation
- Type codes: null 0x00, ACR 0x01, audio sample 0x02, AVI InfoFrame 0x82, audio InfoFrame 0x84.
- ACR counter: counts 0..ACR_PERIOD-1, wraps; on wrap sets `acr_pending` (saturating flag, no multi-count).
- `video_frame_start` sets `avi_pending` and `aif_pending`.
- On `packet_enable`, priority: `acr_pending` → ACR; else FIFO non-empty → audio sample (pop); else `avi_pending` → AVI; else `aif_pending` → audio InfoFrame; else null. Selected flag clears.
- Decision uses flag/FIFO state before this cycle's updates.
- Simultaneous set and clear of a flag: set wins (flag stays pending).
- FIFO: push when `audio_sample_valid && audio_sample_ready`; `audio_sample_ready` = !full, combinational from registered occupancy. Push and pop in same cycle allowed when not full; when full, pop only (ready low). Pop of empty never occurs (priority guarantees).
- Occupancy width $clog2(FIFO_DEPTH)+1; read/write pointers wrap modulo FIFO_DEPTH.

## Timing
- Decision at edge with `packet_enable` high (cycle t); `packet_type` and `sample_word_out` valid from t+1, held until next decision.
- `asp_advance` high exactly at t+1 when audio sample chosen, else low.
- FIFO write latency 1: sample pushed at t poppable at t+1.
- Reset values: `packet_type` 0x00, `sample_word_out` 0, `asp_advance` 0, `audio_sample_ready` 1 (FIFO empty), ACR counter 0, all pending flags 0.
- Reset mid-slot: outputs return to reset values next edge; buffered samples discarded; `packet_enable` during reset ignored.

## Configuration
- `PACKET_SCHEDULER_INFOFRAME_EN` defined: AVI/audio InfoFrame scheduling as above.
- Undefined: `avi_pending`/`aif_pending` tied 0, `video_frame_start` ignored; slot choices limited to ACR, audio sample, null. Ports unchanged.

## Structure
- Package `hdmi_packet_pkg`: type-code constants (`PKT_NULL`, `PKT_ACR`, `PKT_AUDIO_SAMPLE`, `PKT_AVI`, `PKT_AUDIO_INFOFRAME`), shared with packet generators and the packet mux.
- Sub-module `audio_sample_fifo`: parameterised synchronous FIFO (depth, width), exposes full/empty/push/pop; scheduler holds priority logic, counter and flags.

## Test plan
- ACR_PERIOD=8, no audio, no frame starts, `packet_enable` every 32 cycles → first slot after cycle 8 is 0x01, others 0x00; ACR never issued twice per period.
- Push 3 samples (L=0x12345, R=0x6789A), then 3 `packet_enable` with no ACR pending → three 0x02 slots, `sample_word_out` in push order, `asp_advance` pulse at t+1 each.
- Push 4 samples with FIFO_DEPTH=4 → `audio_sample_ready` low; push+pop same cycle when full → occupancy 3, ready high next cycle, offered sample not lost.
- `video_frame_start`, ACR pending, 1 sample buffered, 4 slots → order 0x01, 0x02, 0x82, 0x84 (macro defined); 0x01, 0x02, 0x00, 0x00 (undefined).
- ACR wrap coinciding with ACR-selecting `packet_enable` → `acr_pending` remains set, next slot 0x01.
- `reset` asserted with 2 samples buffered and 0x02 on output → next edge `packet_type` 0x00, ready 1, next slot after release 0x00.
